// File: rtl/tx_spatial_cb_if.sv
// Wide-to-lanes AXI-Stream bundle for tx_spatial_cb.
// The slave modport is the splitter's view: it sinks the wide stream and sources the lane streams.
// The master modport is the surrounding environment's view.
interface tx_spatial_cb_if #(
  parameter int unsigned DWIDTH_IN  = 240,
  parameter int unsigned DWIDTH_OUT = 240,
  parameter int unsigned N_CHANNEL  = 1
);
  logic [DWIDTH_IN-1:0]    s_axis_tdata;
  logic [DWIDTH_IN/8-1:0]  s_axis_tkeep;
  logic                    s_axis_tlast;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;

  logic [DWIDTH_OUT-1:0]   m_axis_tdata [N_CHANNEL];
  logic [DWIDTH_OUT/8-1:0] m_axis_tkeep [N_CHANNEL];
  logic [N_CHANNEL-1:0]    m_axis_tlast;
  logic [N_CHANNEL-1:0]    m_axis_tvalid;
  logic [N_CHANNEL-1:0]    m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/tx_spatial_cb.sv
// Transmit-side spatial channel bonding: splits one wide AXI-Stream beat across N_CHANNEL lanes,
// each lane holding a one-entry output register so lanes may drain with up to one beat of skew.
module tx_spatial_cb #(
  parameter int unsigned DWIDTH_IN  = 240,
  parameter int unsigned DWIDTH_OUT = 240,
  parameter int unsigned N_CHANNEL  = 1
) (
  input logic             clk,
  input logic             rst,
  tx_spatial_cb_if.slave  axis_io
);
  localparam int unsigned KeepW = DWIDTH_IN / 8 / N_CHANNEL;

  logic [N_CHANNEL-1:0]  pend_q, pend_d;
  logic [N_CHANNEL-1:0]  tlast_q, tlast_d;
  logic [N_CHANNEL-1:0]  load;
  logic [DWIDTH_OUT-1:0] tdata_q [N_CHANNEL];
  logic [KeepW-1:0]      tkeep_q [N_CHANNEL];
  logic                  ready;
  logic                  accept;
  int                    lowest;

  // Input ready: every lane must be empty or draining this cycle; forced low during reset.
  always_comb begin
    ready = ~rst & (&(~pend_q | axis_io.m_axis_tready));
    accept = ready & axis_io.s_axis_tvalid;
    axis_io.s_axis_tready = ready;
  end

  // Lane participation, tlast placement and pending next-state; a reload beats a drain.
  always_comb begin
    // Empty last beat falls back to the top lane alone.
    lowest = int'(N_CHANNEL) - 1;
    for (int i = int'(N_CHANNEL) - 1; i >= 0; i--) begin
      if (|axis_io.s_axis_tkeep[i*KeepW +: KeepW]) lowest = i;
    end
    load    = '0;
    tlast_d = '0;
    pend_d  = '0;
    for (int i = 0; i < int'(N_CHANNEL); i++) begin
      load[i]    = accept & (~axis_io.s_axis_tlast | (i >= lowest));
      tlast_d[i] = axis_io.s_axis_tlast & (i == lowest);
      pend_d[i]  = load[i] | (pend_q[i] & ~axis_io.m_axis_tready[i]);
    end
  end

  // Lane registers: load the input slice on acceptance, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      tlast_q <= '0;
      for (int i = 0; i < int'(N_CHANNEL); i++) begin
        tdata_q[i] <= '0;
        tkeep_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < int'(N_CHANNEL); i++) begin
        if (load[i]) begin
          tdata_q[i] <= axis_io.s_axis_tdata[i*DWIDTH_OUT +: DWIDTH_OUT];
          tkeep_q[i] <= axis_io.s_axis_tkeep[i*KeepW +: KeepW];
          tlast_q[i] <= tlast_d[i];
        end
      end
    end
  end

  // Drive the lane outputs straight from the registers.
  always_comb begin
    axis_io.m_axis_tvalid = pend_q;
    axis_io.m_axis_tlast  = tlast_q;
    for (int i = 0; i < int'(N_CHANNEL); i++) begin
      axis_io.m_axis_tdata[i] = tdata_q[i];
      axis_io.m_axis_tkeep[i] = tkeep_q[i];
    end
  end
endmodule

// File: tb/tb_tx_spatial_cb.sv
// Randomized bench for tx_spatial_cb (4 lanes x 64 bits) against a per-lane queue scoreboard.
module tb_tx_spatial_cb;
  localparam int NCh  = 4;
  localparam int DOut = 64;
  localparam int DIn  = NCh * DOut;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  beat_t lane_q [NCh][$];

  tx_spatial_cb_if #(.DWIDTH_IN(DIn), .DWIDTH_OUT(DOut), .N_CHANNEL(NCh)) axis_if ();

  tx_spatial_cb #(.DWIDTH_IN(DIn), .DWIDTH_OUT(DOut), .N_CHANNEL(NCh)) dut (
    .clk     (clk),
    .rst     (rst),
    .axis_io (axis_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every lane and the input ready against the scoreboard.
  task automatic compare_outputs(output logic exp_ready);
    exp_ready = 1'b1;
    for (int i = 0; i < NCh; i++) begin
      check($sformatf("lane%0d_valid", i), 256'(axis_if.m_axis_tvalid[i]),
            256'(lane_q[i].size() != 0));
      if (lane_q[i].size() != 0) begin
        check($sformatf("lane%0d_data", i), 256'(axis_if.m_axis_tdata[i]),
              256'(lane_q[i][0].data));
        check($sformatf("lane%0d_keep", i), 256'(axis_if.m_axis_tkeep[i]),
              256'(lane_q[i][0].keep));
        check($sformatf("lane%0d_last", i), 256'(axis_if.m_axis_tlast[i]),
              256'(lane_q[i][0].last));
        if (!axis_if.m_axis_tready[i]) exp_ready = 1'b0;
      end
    end
    check("s_tready", 256'(axis_if.s_axis_tready), 256'(exp_ready));
  endtask

  // Scoreboard update for one clock: drains first, then the accepted beat is distributed.
  task automatic update_model(input logic exp_ready);
    int k;
    beat_t b;
    for (int i = 0; i < NCh; i++)
      if (lane_q[i].size() != 0 && axis_if.m_axis_tready[i]) void'(lane_q[i].pop_front());
    if (exp_ready && axis_if.s_axis_tvalid) begin
      k = NCh - 1;
      if (axis_if.s_axis_tlast) begin
        for (int i = 0; i < NCh; i++) begin
          if (axis_if.s_axis_tkeep[8*i +: 8] != 8'h00) begin
            k = i;
            break;
          end
        end
      end else begin
        k = 0;
      end
      for (int i = k; i < NCh; i++) begin
        b.data = axis_if.s_axis_tdata[64*i +: 64];
        b.keep = axis_if.s_axis_tkeep[8*i +: 8];
        b.last = axis_if.s_axis_tlast && (i == k);
        lane_q[i].push_back(b);
        if (lane_q[i].size() > 1) check($sformatf("lane%0d_depth", i), 256'(lane_q[i].size()), 256'(1));
      end
    end
  endtask

  task automatic drive_random();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
    axis_if.s_axis_tdata = d;
    case ($urandom_range(0, 5))
      0:       axis_if.s_axis_tkeep = 32'hFFFF0000;
      1:       axis_if.s_axis_tkeep = 32'hFFFFFF0F;
      2:       axis_if.s_axis_tkeep = 32'h00000000;
      3:       axis_if.s_axis_tkeep = 32'hFF000000;
      4:       axis_if.s_axis_tkeep = $urandom;
      default: axis_if.s_axis_tkeep = 32'hFFFFFFFF;
    endcase
    axis_if.s_axis_tlast  = ($urandom_range(0, 2) == 0);
    axis_if.s_axis_tvalid = ($urandom_range(0, 4) != 0);
    for (int i = 0; i < NCh; i++) axis_if.m_axis_tready[i] = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    logic exp_ready;
    axis_if.s_axis_tdata  = '0;
    axis_if.s_axis_tkeep  = '0;
    axis_if.s_axis_tlast  = 1'b0;
    axis_if.s_axis_tvalid = 1'b1;
    axis_if.m_axis_tready = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 256'(axis_if.s_axis_tready), 256'(0));
    check("rst_tvalid", 256'(axis_if.m_axis_tvalid), 256'(0));
    check("rst_tlast", 256'(axis_if.m_axis_tlast), 256'(0));
    for (int i = 0; i < NCh; i++) begin
      check($sformatf("rst_data%0d", i), 256'(axis_if.m_axis_tdata[i]), 256'(0));
      check($sformatf("rst_keep%0d", i), 256'(axis_if.m_axis_tkeep[i]), 256'(0));
    end
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        // Asynchronous reset between edges: outputs must collapse before the next edge.
        #2 rst = 1'b1;
        #1;
        check("arst_tvalid", 256'(axis_if.m_axis_tvalid), 256'(0));
        check("arst_tready", 256'(axis_if.s_axis_tready), 256'(0));
        for (int i = 0; i < NCh; i++) lane_q[i].delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
      end
      drive_random();
      @(negedge clk);
      compare_outputs(exp_ready);
      update_model(exp_ready);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tx_spatial_cb.md
Name: tx_spatial_cb

Overview:
- Transmit-side spatial channel bonding.
- Takes one wide AXI-Stream beat and splits it across N_CHANNEL independent lane streams, one DWIDTH_OUT slice per lane. It is the counterpart of the RX spatial bonding merger.
- Packets fill lanes from the top lane (N_CHANNEL-1) downward. On the final beat of a packet, only the populated upper lanes are emitted, and tlast sits on the lowest populated lane.
- Each lane has a one-entry output register, so lanes can drain independently with up to one beat of skew.

Parameters:
- DWIDTH_IN, 240, width of the wide input bus in bits. Must equal N_CHANNEL*DWIDTH_OUT.
- DWIDTH_OUT, 240, width of each lane in bits. Must be a multiple of 8.
- N_CHANNEL, 1, number of bonded lanes (at least 1).

Ports:
- clk  input  1  clock; all logic in this single domain.
- rst  input  1  reset, asynchronous, active-high.
- s_axis_tdata  input  DWIDTH_IN  wide input data. Lane i slice = bits [(i+1)*DWIDTH_OUT-1 : i*DWIDTH_OUT].
- s_axis_tkeep  input  DWIDTH_IN/8  byte enables; lane i slice = bits [(i+1)*DWIDTH_OUT/8-1 : i*DWIDTH_OUT/8].
- s_axis_tlast  input  1  end of packet.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when tvalid&tready.
- m_axis_tdata  output  [DWIDTH_OUT-1:0] x N_CHANNEL (unpacked)  per-lane data.
- m_axis_tkeep  output  [DWIDTH_OUT/8-1:0] x N_CHANNEL (unpacked)  per-lane byte enables.
- m_axis_tlast  output  N_CHANNEL  per-lane tlast.
- m_axis_tvalid  output  N_CHANNEL  per-lane valid.
- m_axis_tready  input  N_CHANNEL  per-lane ready.

Behaviour:
- Per-lane state: pend[i] plus the registered tdata, tkeep and tlast for that lane. m_axis_tvalid[i] = pend[i].
- Reset (asynchronous, takes effect immediately):
  - pend, m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tkeep all clear to 0.
  - s_axis_tready is forced to 0 while rst is high.
  - Reset mid-operation discards any pending lane beats. There is no partial replay.
- Input ready is combinational from lane state: s_axis_tready = ~rst & AND over i of (~pend[i] | m_axis_tready[i]). A beat is accepted only when every lane is empty or draining in the same cycle.
- Lane drain: when pend[i] & m_axis_tready[i], pend[i] clears unless the lane is reloaded in the same cycle. Load wins.
- Lane participation for an accepted beat:
  - tlast=0: all lanes participate. tlast out = 0 on every lane. tkeep passes through unchanged, including partial or zero lanes.
  - tlast=1: k = lowest lane index whose tkeep slice is non-zero. Lanes k..N_CHANNEL-1 participate; lanes below k are not loaded (pend stays 0, tvalid stays low).
  - Lane k gets tlast=1; higher participating lanes get tlast=0.
  - If the whole tkeep is 0 with tlast=1, k = N_CHANNEL-1: lane N_CHANNEL-1 is emitted with keep 0 and tlast=1.
- Loaded lane registers take the input slice: tdata slice, tkeep slice and the computed tlast.
- Latency: 1 cycle from acceptance to m_axis_tvalid.
- Throughput: 1 beat/cycle while every participating lane's ready is high.
- Skew: a stalled lane holds its beat while other lanes drain. No new input is accepted until the stalled lane drains, so lanes never diverge by more than one beat.
- Output data of a lane is stable while m_axis_tvalid[i]=1 and m_axis_tready[i]=0, per AXI-Stream.
- Upstream must not assert tvalid with a last beat whose populated lanes are non-contiguous from the top. Behaviour in that case is defined only by the k rule above.
- N_CHANNEL=1 degenerates to a single registered slice. Lane 0 always participates and tlast passes through.

Test Plan:
Configuration for all scenarios: N_CHANNEL=4, DWIDTH_OUT=64, DWIDTH_IN=256.
1. Five back-to-back full beats (tkeep=32'hFFFFFFFF, tlast=0, all m ready=1)
   -> each beat appears on all 4 lanes one cycle after acceptance; lane i data = input bits [64i+63:64i]; tlast=4'b0000; s_axis_tready stays 1 throughout.
2. Last beat with tkeep=32'hFFFF0000
   -> m_axis_tvalid=4'b1100; m_axis_tlast=4'b0100; lanes 3 and 2 keep=8'hFF; lanes 1 and 0 never valid.
3. Last beat with tkeep=32'hFFFFFF0F
   -> tvalid=4'b1111; tlast=4'b0001; lane 0 keep=8'h0F.
4. m_axis_tready[1]=0 for 3 cycles with a second beat waiting
   -> lanes 0, 2 and 3 drain; lane 1 holds data and keep stable; s_axis_tready=0 until lane 1 drains; the second beat is then accepted with no loss or duplication.
5. rst asserted asynchronously mid-cycle while lanes hold beats
   -> m_axis_tvalid drops to 0 before the next clk edge; s_axis_tready=0; after release, the first accepted beat emits normally with no stale data.
6. tlast=1 with tkeep=0
   -> tvalid=4'b1000; tlast=4'b1000; lane 3 keep=8'h00.
